sram_like_responder: RTL
========================

# sram_like_responder

Slave end of the SRAM-like data bus: accepts one request at a time (`req`/`addr_ok`), services it from an internal byte-enabled word memory after a fixed wait-state latency, and completes it with a one-cycle `data_ok` pulse carrying read data.

It sits opposite the memory-stage SRAM-like initiator. It serves as a simulation and FPGA target for that initiator, and as the template for later bridges to AXI.

## Interface
- `ADDR_WIDTH`, 10: word-index bits of the backing store (2^ADDR_WIDTH words of 32 bits).
- `LATENCY`, 2: cycles from the accepting edge to the `data_ok` cycle; legal range 1..15.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `req`  in  1  request valid from the initiator.
- `wr`  in  1  1 = write, 0 = read.
- `select`  in  4  byte-lane enables for writes.
- `size`  in  3  0 = byte, 1 = half, 2 = word; other values reserved.
- `addr`  in  32  byte address.
- `wdata`  in  32  write data.
- `addr_ok`  out  1  request accepted this cycle.
- `data_ok`  out  1  transaction complete; one-cycle pulse.
- `rdata`  out  32  read word; valid only while `data_ok`=1.
- `busy`  out  1  a transaction is outstanding (state ≠ IDLE).
- `err`  out  1  completed transaction was rejected; qualified by `data_ok`.

## Operation
- FSM states:
  - IDLE: `addr_ok` = `req` (combinational). On an edge with `req`=1, latch `wr`, `select`, `size`, `addr`, `wdata` and load the counter with LATENCY-1. Next state is WAIT, or RESP when LATENCY=1.
  - WAIT: decrement the counter; when it reads 0, the next state is RESP.
  - RESP: `data_ok`=1; next state is IDLE unconditionally.
- `addr_ok` is 0 in WAIT and RESP. Only one transaction is ever outstanding. A `req` held high after acceptance is ignored until IDLE.
- Word index is `addr[ADDR_WIDTH+1:2]`. Upper address bits are ignored, so addresses wrap modulo 2^ADDR_WIDTH words.
- Write: on the edge leaving RESP, bytes whose `select` bit is 1 are written from the latched `wdata`. `rdata` is 0 for writes.
- Read: `rdata` returns the full stored word regardless of `select`/`size`. The initiator extracts lanes.
- A write followed by a read to the same word returns the new data.
- `busy` = (state ≠ IDLE).

## Timing
- Reset (`rst`=0, asynchronous): state → IDLE, counter → 0, latched request → 0.
  - `addr_ok`=0, `data_ok`=0, `rdata`=0, `busy`=0, `err`=0 while `rst`=0.
  - Memory contents are not reset.
- Reset mid-transaction aborts it. No `data_ok` is produced, and an aborted write does not modify memory.
- Accept at edge t (IDLE, `req`=1) → `data_ok` high during cycle t+LATENCY → IDLE at cycle t+LATENCY+1.
- Back-to-back throughput: one transaction per LATENCY+1 cycles; the next `addr_ok` comes no earlier than the cycle after `data_ok`.
- `rdata` and `data_ok` are registered outputs. `addr_ok` is the only combinational path (`req` → `addr_ok`).

## Configuration
- `SRAM_RESP_ALIGN_CHECK_EN` defined:
  - A latched request is rejected when any of these holds:
    - `size`=1 and `addr[0]`=1;
    - `size`=2 and `addr[1:0]`≠0;
    - `size`>2;
    - `select`=0 for a write.
  - A rejected transaction completes normally with `err`=1 during the `data_ok` cycle, `rdata`=0, and no memory write.
- Not defined: `err` is tied to 0, and every transaction executes per `select`.

## Structure
- Shared package/defines: FSM state encoding (IDLE/WAIT/RESP), size encodings (SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2), and `RegBus` width from `defines.v`.
- One sub-module, `sram_resp_mem`: single-port 2^ADDR_WIDTH×32 RAM with 4 byte write-enables and a synchronous read.
- FSM, latency counter and request latch stay in the top module.

## Test plan
- LATENCY=2: read addr 0x0000_0010 after preload 0xDEADBEEF at word 4. `addr_ok` is high in the `req` cycle, and `data_ok` comes 2 cycles later with `rdata`=0xDEADBEEF.
- Write 0x11223344 with `select`=4'b0101 to addr 0x20 over 0xAABBCCDD, then read addr 0x20 → `rdata`=0xAA22CC44.
- `req` held high continuously for 3 reads with LATENCY=1 → `addr_ok` pulses every 2 cycles, each followed 1 cycle later by one `data_ok`, and never two outstanding.
- Assert `rst`=0 during WAIT of a write → no `data_ok`, `busy`=0 immediately, and a read of that word afterwards returns the old value.
- Address wrap, ADDR_WIDTH=10: write to 0x0000_1000 → a read of 0x0000_0000 returns the written value.
- With `SRAM_RESP_ALIGN_CHECK_EN`, size=2 write to addr 0x22 → `data_ok`=1, `err`=1, memory unchanged. Without the macro the same stimulus gives `err`=0 and the write lands in word 8.

Source files
------------

// File: rtl/sram_like_responder_pkg.sv
// sram_like_responder_pkg: shared types and helpers for the SRAM-like responder.
// Holds the FSM encoding, size codes and the alignment/lane rule used when SRAM_RESP_ALIGN_CHECK_EN is set.
`default_nettype none

package sram_like_responder_pkg;

   localparam int REG_BUS = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [2:0] SIZE_BYTE = 3'd0;
   localparam logic [2:0] SIZE_HALF = 3'd1;
   localparam logic [2:0] SIZE_WORD = 3'd2;

   // True when a request would be rejected by the alignment/lane rule.
   function automatic logic f_reject(input logic       i_wr,
                                     input logic [3:0] i_select,
                                     input logic [2:0] i_size,
                                     input logic [1:0] i_addr_lo);
      logic w_bad;
      w_bad = 1'b0;
      if ((i_size == SIZE_HALF) && i_addr_lo[0])
         w_bad = 1'b1;
      if ((i_size == SIZE_WORD) && (i_addr_lo != 2'b00))
         w_bad = 1'b1;
      if (i_size > SIZE_WORD)
         w_bad = 1'b1;
      if (i_wr && (i_select == 4'b0000))
         w_bad = 1'b1;
      return w_bad;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sram_like_responder_if.sv
// sram_like_responder_if: SRAM-like request/response bus between initiator (master) and responder (slave).
// Revision: 1.0
`default_nettype none

interface sram_like_responder_if;
   import sram_like_responder_pkg::*;

   logic               req;
   logic               wr;
   logic [3:0]         select;
   logic [2:0]         size;
   logic [REG_BUS-1:0] addr;
   logic [REG_BUS-1:0] wdata;
   logic               addr_ok;
   logic               data_ok;
   logic [REG_BUS-1:0] rdata;
   logic               busy;
   logic               err;

   modport master (
      output req, wr, select, size, addr, wdata,
      input  addr_ok, data_ok, rdata, busy, err
   );

   modport slave (
      input  req, wr, select, size, addr, wdata,
      output addr_ok, data_ok, rdata, busy, err
   );

endinterface

`default_nettype wire

// File: rtl/sram_like_responder_mem.sv
// sram_resp_mem: single-port 2^ADDR_WIDTH x 32 RAM, byte write enables, synchronous read.
// Revision: 1.0
`default_nettype none

module sram_resp_mem #(
   parameter int ADDR_WIDTH = 10
) (
   input  wire logic                  clk,
   input  wire logic [ADDR_WIDTH-1:0] i_addr,
   input  wire logic [3:0]            i_we,
   input  wire logic [31:0]           i_wdata,
   output logic      [31:0]           o_rdata
);

   logic [31:0] r_mem [2**ADDR_WIDTH];
   logic [31:0] r_rdata;

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (i_we[b])
            r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
      r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/sram_like_responder.sv
// sram_like_responder: one-outstanding SRAM-like slave with fixed LATENCY and byte-enabled word store.
// Optional SRAM_RESP_ALIGN_CHECK_EN rejects misaligned/empty-lane requests with err. Revision: 1.0
`default_nettype none

module sram_like_responder
   import sram_like_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input  wire logic            clk,
   input  wire logic            rst,
   sram_like_responder_if.slave bus
);

   localparam logic [3:0] C_LAT_M1 = 4'(LATENCY - 1);

   state_t                r_state;
   logic [3:0]            r_cnt;
   logic                  r_wr;
   logic [3:0]            r_sel;
   logic [ADDR_WIDTH-1:0] r_word;
   logic [31:0]           r_wdata;
   logic                  r_err;
   logic                  r_data_ok;

   logic                  w_req_err;
   logic [ADDR_WIDTH-1:0] w_mem_addr;
   logic [3:0]            w_mem_we;
   logic [31:0]           w_mem_q;
   logic                  w_unused;

`ifdef SRAM_RESP_ALIGN_CHECK_EN
   assign w_req_err = f_reject(bus.wr, bus.select, bus.size, bus.addr[1:0]);
`else
   assign w_req_err = 1'b0;
`endif

   assign w_unused = ^{bus.addr[31:ADDR_WIDTH+2], bus.addr[1:0], bus.size};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= 4'd0;
         r_wr      <= 1'b0;
         r_sel     <= 4'd0;
         r_word    <= '0;
         r_wdata   <= 32'd0;
         r_err     <= 1'b0;
         r_data_ok <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.req) begin
                  r_wr    <= bus.wr;
                  r_sel   <= bus.select;
                  r_word  <= bus.addr[ADDR_WIDTH+1:2];
                  r_wdata <= bus.wdata;
                  r_err   <= w_req_err;
                  r_cnt   <= C_LAT_M1;
                  if (LATENCY == 1) begin
                     r_state   <= ST_RESP;
                     r_data_ok <= 1'b1;
                  end else begin
                     r_state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_state   <= ST_RESP;
                  r_data_ok <= 1'b1;
               end
            end
            ST_RESP: begin
               r_state   <= ST_IDLE;
               r_data_ok <= 1'b0;
            end
            default: begin
               r_state   <= ST_IDLE;
               r_data_ok <= 1'b0;
            end
         endcase
      end
   end

   // The RAM reads every edge; in IDLE it follows the bus so a LATENCY=1 read is ready in RESP.
   assign w_mem_addr = (r_state == ST_IDLE) ? bus.addr[ADDR_WIDTH+1:2] : r_word;
   assign w_mem_we   = ((r_state == ST_RESP) && r_wr && !r_err) ? r_sel : 4'b0000;

   sram_resp_mem #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk     (clk),
      .i_addr  (w_mem_addr),
      .i_we    (w_mem_we),
      .i_wdata (r_wdata),
      .o_rdata (w_mem_q)
   );

   assign bus.addr_ok = rst && (r_state == ST_IDLE) && bus.req;
   assign bus.data_ok = r_data_ok;
   assign bus.rdata   = (r_data_ok && !r_wr && !r_err) ? w_mem_q : 32'd0;
   assign bus.busy    = (r_state != ST_IDLE);
   assign bus.err     = r_data_ok && r_err;

endmodule

`default_nettype wire
